perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised performance-counter bank for the RISC-V core: one free-running cycle counter plus NUM_EVENTS event counters, each CNT_WIDTH bits wide. Counters are read and written as 32-bit LO/HI words over a simple single-cycle register port driven by the MMIO decoder. The bank adds per-counter enables, global freeze, sticky overflow flags and atomic wide reads.

## Interface
- NUM_EVENTS, 4: number of event counters (1..14); counter index 0 is cycles, 1..NUM_EVENTS are events.
- CNT_WIDTH, 48: counter width (33..64).
- ADDR_W, 5: word-address width; must cover 4 + 2*(NUM_EVENTS+1) words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- event_in  in  NUM_EVENTS  bit e-1 high in a cycle means "increment counter e by 1".
- reset_counters  in  1  synchronous clear of all counters, overflow flags and shadow.
- rd_en  in  1  read strobe.
- wr_en  in  1  write strobe.
- addr  in  ADDR_W  word address.
- wr_data  in  32  write data.
- rd_data  out  32  registered read data.
- rd_valid  out  1  high one cycle after rd_en.

## Operation
Register map (word address):
- 0 CTRL: bit0 enable, bit1 freeze, bit2 clear_all (write-1 pulse, reads 0). Other bits read 0.
- 1 EN_MASK: bits [NUM_EVENTS:0]; bit k enables counter k.
- 2 OVF: bits [NUM_EVENTS:0], sticky; write-1-to-clear.
- 3: reserved; reads 0, writes ignored.
- 4+2k: counter k LO (bits 31:0).
- 5+2k: counter k HI (bits CNT_WIDTH-1:32, zero-extended).
- Unmapped addresses: read 0, write ignored.

Counting:
- Counter k increments when enable=1, freeze=0 and EN_MASK[k]=1. Counter 0 increments every such cycle; counter k≥1 also requires event_in[k-1].
- At all-ones, an increment wraps the counter to 0 and sets OVF[k] in the same edge.

Priority per edge, highest first:
1. reset_counters or CTRL.clear_all write: all counters, OVF and shadow_valid go to 0. CTRL and EN_MASK are unchanged.
2. A software write to a counter's LO/HI word replaces that half. No increment is applied to that counter this cycle.
3. Increment.

Other simultaneous events:
- OVF set and a W1C clear of the same bit in one cycle: the set wins.

Atomic wide read:
- A LO read of counter k copies the live HI bits of k into hi_shadow and records shadow_idx=k, shadow_valid=1.
- A HI read of counter k returns hi_shadow when shadow_valid && shadow_idx==k. Otherwise it returns live HI.
- Any write to counter k's LO or HI clears shadow_valid if shadow_idx==k.

Read/write collision:
- rd_en and wr_en to the same address in one cycle: rd_data returns the pre-write value.

## Timing
- Reset values: all counters 0; OVF 0; CTRL.enable=1, freeze=0; EN_MASK all ones; shadow_valid 0; rd_data 0; rd_valid 0.
- Reset is asynchronous assert, synchronous release. The first increment happens on the first rising edge with rst high.
- Read latency is 1 cycle. rd_data/rd_valid update on the edge after rd_en and hold rd_data until the next read. rd_valid is high for exactly one cycle per rd_en.
- A read returns the counter value before that edge's increment.
- Writes take effect at the edge where wr_en is sampled. Counting resumes from the written value on the following edge.
- Back-to-back reads every cycle are supported; there is no stall or backpressure.
- Reset mid-operation: all state returns to reset values immediately. An in-flight read produces no rd_valid.

## Test plan
- Reset release, 10 idle cycles, then read addr 4 → rd_valid next cycle; rd_data=10 (count taken from the cycle before the read edge; exact value checked against the model). Addr 5 → 0.
- EN_MASK=0b00010 and event_in[0] pulsed 7 times: counter 1 LO=7; counter 0 stays frozen at its masked value; counter 2 = 0.
- Write counter 1 LO=0xFFFFFFFF and HI=0xFFFF (CNT_WIDTH=48), then one event → counter 1 = 0, OVF=0b00010. Write OVF=0b00010 → OVF reads 0. W1C in the same cycle as a new wrap → OVF stays set.
- Counter 0 LO=0xFFFFFFFE, HI=0: read LO, wait 4 cycles, read HI → HI=0 (shadow), not 1. Read HI of counter 1 instead → live value.
- Set CTRL.freeze=1 for 20 cycles → no counter changes. Counter writes still apply. Clearing freeze resumes counting.
- Assert reset_counters for one cycle while counting, or write CTRL=0b101 → all counters and OVF read 0; CTRL.enable and EN_MASK keep their values.

Source files
------------

// File: rtl/perf_counter_bank.sv
// perf_counter_bank
// Performance-counter bank: counter 0 counts cycles, counters 1..NUM_EVENTS
// count pulses on event_in_i. Software reads and writes the counters as
// 32-bit LO/HI words through a single-cycle register port.
//
// Ports:
//   clk_i             clock, all state updates on the rising edge
//   rst_ni            asynchronous active-low reset
//   event_in_i        bit e-1 increments counter e
//   reset_counters_i  synchronous clear of counters, OVF and the HI shadow
//   rd_en_i / wr_en_i read / write strobes
//   addr_i            word address
//   wr_data_i         write data
//   rd_data_o         registered read data, held until the next read
//   rd_valid_o        one-cycle pulse one edge after rd_en_i
//
// Word map: 0 CTRL {clear_all, freeze, enable}, 1 EN_MASK, 2 OVF (W1C),
// 3 reserved, 4+2k counter k LO, 5+2k counter k HI (zero-extended).
module perf_counter_bank #(
  parameter int unsigned NUM_EVENTS = 4,
  parameter int unsigned CNT_WIDTH  = 48,
  parameter int unsigned ADDR_W     = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_EVENTS-1:0] event_in_i,
  input  logic                  reset_counters_i,
  input  logic                  rd_en_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [31:0]           wr_data_i,
  output logic [31:0]           rd_data_o,
  output logic                  rd_valid_o
);

  localparam int unsigned NCNT    = NUM_EVENTS + 1;
  localparam int unsigned HW      = CNT_WIDTH - 32;
  localparam int unsigned IDX_W   = (NCNT > 1) ? $clog2(NCNT) : 1;
  localparam int unsigned CNT_END = 4 + 2 * NCNT;

  logic [CNT_WIDTH-1:0] cnt_q [NCNT];
  logic [CNT_WIDTH-1:0] cnt_d [NCNT];
  logic                 ctrl_en_q, ctrl_en_d;
  logic                 ctrl_frz_q, ctrl_frz_d;
  logic [NCNT-1:0]      en_mask_q, en_mask_d;
  logic [NCNT-1:0]      ovf_q, ovf_d, ovf_set;
  logic [HW-1:0]        hi_shadow_q, hi_shadow_d;
  logic [IDX_W-1:0]     shadow_idx_q, shadow_idx_d;
  logic                 shadow_valid_q, shadow_valid_d;
  logic [31:0]          rd_data_q, rd_data_d;
  logic                 rd_valid_q;

  // Address decode
  logic              addr_is_cnt, addr_hi;
  logic [ADDR_W-1:0] cnt_word;
  logic [IDX_W-1:0]  addr_idx;
  logic              wr_ctrl, wr_mask, wr_ovf, wr_cnt, clear_all, count_on;
  logic [31:0]       rd_word;

  assign addr_is_cnt = (32'(addr_i) >= 32'd4) && (32'(addr_i) < CNT_END);
  assign cnt_word    = (addr_i - ADDR_W'(4)) >> 1;
  assign addr_idx    = IDX_W'(cnt_word);
  assign addr_hi     = addr_i[0];

  assign wr_ctrl   = wr_en_i && (addr_i == ADDR_W'(0));
  assign wr_mask   = wr_en_i && (addr_i == ADDR_W'(1));
  assign wr_ovf    = wr_en_i && (addr_i == ADDR_W'(2));
  assign wr_cnt    = wr_en_i && addr_is_cnt;
  assign clear_all = reset_counters_i || (wr_ctrl && wr_data_i[2]);
  assign count_on  = ctrl_en_q && !ctrl_frz_q;

  // Per-counter next state: clear beats software write beats increment.
  for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
    logic                 inc;
    logic                 wr_sel;
    logic [CNT_WIDTH-1:0] cnt_inc;

    if (gi == 0) begin : g_cycle
      assign inc = count_on && en_mask_q[0];
    end else begin : g_event
      assign inc = count_on && en_mask_q[gi] && event_in_i[gi-1];
    end

    assign wr_sel  = wr_cnt && (addr_idx == IDX_W'(gi));
    assign cnt_inc = cnt_q[gi] + CNT_WIDTH'(1);

    assign cnt_d[gi] = clear_all            ? '0 :
                       (wr_sel && !addr_hi) ? {cnt_q[gi][CNT_WIDTH-1:32], wr_data_i} :
                       wr_sel               ? {wr_data_i[HW-1:0], cnt_q[gi][31:0]} :
                       inc                  ? cnt_inc : cnt_q[gi];

    // Wrap from all-ones flags overflow on the same edge.
    assign ovf_set[gi] = !clear_all && !wr_sel && inc && (&cnt_q[gi]);
  end

  // Read mux always sees pre-edge state, so a same-address write is invisible.
  always_comb begin
    rd_word = '0;
    if (addr_is_cnt) begin
      if (!addr_hi) begin
        rd_word = cnt_q[addr_idx][31:0];
      end else if (shadow_valid_q && (shadow_idx_q == addr_idx)) begin
        rd_word = 32'(hi_shadow_q);
      end else begin
        rd_word = 32'(cnt_q[addr_idx][CNT_WIDTH-1:32]);
      end
    end else begin
      case (addr_i)
        ADDR_W'(0): rd_word = {30'd0, ctrl_frz_q, ctrl_en_q};
        ADDR_W'(1): rd_word = 32'(en_mask_q);
        ADDR_W'(2): rd_word = 32'(ovf_q);
        default:    rd_word = '0;
      endcase
    end
  end

  always_comb begin
    ctrl_en_d      = ctrl_en_q;
    ctrl_frz_d     = ctrl_frz_q;
    en_mask_d      = en_mask_q;
    hi_shadow_d    = hi_shadow_q;
    shadow_idx_d   = shadow_idx_q;
    shadow_valid_d = shadow_valid_q;
    rd_data_d      = rd_data_q;

    if (wr_ctrl) begin
      ctrl_en_d  = wr_data_i[0];
      ctrl_frz_d = wr_data_i[1];
    end
    if (wr_mask) begin
      en_mask_d = wr_data_i[NCNT-1:0];
    end

    if (rd_en_i) begin
      rd_data_d = rd_word;
      // A LO read snapshots the live HI so the following HI read is coherent.
      if (addr_is_cnt && !addr_hi) begin
        hi_shadow_d    = cnt_q[addr_idx][CNT_WIDTH-1:32];
        shadow_idx_d   = addr_idx;
        shadow_valid_d = 1'b1;
      end
    end
    // Writing the shadowed counter makes the snapshot stale.
    if (wr_cnt && (shadow_idx_d == addr_idx)) begin
      shadow_valid_d = 1'b0;
    end
    if (clear_all) begin
      shadow_valid_d = 1'b0;
    end
  end

  // A new wrap wins over a simultaneous W1C of the same bit.
  assign ovf_d = clear_all ? '0
               : ((ovf_q & ~(wr_ovf ? wr_data_i[NCNT-1:0] : {NCNT{1'b0}})) | ovf_set);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NCNT); i++) begin
        cnt_q[i] <= '0;
      end
      ctrl_en_q      <= 1'b1;
      ctrl_frz_q     <= 1'b0;
      en_mask_q      <= '1;
      ovf_q          <= '0;
      hi_shadow_q    <= '0;
      shadow_idx_q   <= '0;
      shadow_valid_q <= 1'b0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NCNT); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ctrl_en_q      <= ctrl_en_d;
      ctrl_frz_q     <= ctrl_frz_d;
      en_mask_q      <= en_mask_d;
      ovf_q          <= ovf_d;
      hi_shadow_q    <= hi_shadow_d;
      shadow_idx_q   <= shadow_idx_d;
      shadow_valid_q <= shadow_valid_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_en_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;

  localparam int NE   = 4;
  localparam int CW   = 48;
  localparam int AW   = 5;
  localparam int NCNT = NE + 1;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b1;
  logic [NE-1:0] event_in = '0;
  logic          reset_counters = 1'b0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_data_o;
  logic          rd_valid_o;

  perf_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .ADDR_W(AW)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .event_in_i       (event_in),
    .reset_counters_i (reset_counters),
    .rd_en_i          (rd_en),
    .wr_en_i          (wr_en),
    .addr_i           (addr),
    .wr_data_i        (wr_data),
    .rd_data_o        (rd_data_o),
    .rd_valid_o       (rd_valid_o)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  longint unsigned m_cnt [NCNT];
  logic [63:0]     cmax = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - CW);
  logic            m_en, m_frz;
  logic [NCNT-1:0] m_mask, m_ovf;
  logic [63:0]     m_sh;
  int              m_sh_idx;
  bit              m_sh_valid;
  logic [31:0]     m_rd_data;
  bit              m_rd_valid;

  task automatic m_reset();
    for (int j = 0; j < NCNT; j++) m_cnt[j] = 0;
    m_en = 1'b1; m_frz = 1'b0; m_mask = '1; m_ovf = '0;
    m_sh = '0; m_sh_idx = 0; m_sh_valid = 0;
    m_rd_data = '0; m_rd_valid = 0;
  endtask

  function automatic logic [31:0] m_read(int a);
    int k;
    if (a == 0) return {30'd0, m_frz, m_en};
    if (a == 1) return 32'(m_mask);
    if (a == 2) return 32'(m_ovf);
    if (a >= 4 && a < 4 + 2 * NCNT) begin
      k = (a - 4) / 2;
      if (a % 2 == 0) return m_cnt[k][31:0];
      if (m_sh_valid && m_sh_idx == k) return m_sh[31:0];
      return 32'(m_cnt[k] >> 32);
    end
    return 32'd0;
  endfunction

  task automatic m_step();
    int a, k;
    bit is_cnt, is_hi, clr, on;
    logic [NCNT-1:0] setv;
    a      = int'(addr);
    is_cnt = (a >= 4) && (a < 4 + 2 * NCNT);
    k      = is_cnt ? (a - 4) / 2 : 0;
    is_hi  = (a % 2 == 1);
    m_rd_valid = rd_en;
    if (rd_en) begin
      m_rd_data = m_read(a);
      if (is_cnt && !is_hi) begin
        m_sh = m_cnt[k] >> 32; m_sh_idx = k; m_sh_valid = 1;
      end
    end
    on   = m_en && !m_frz;
    clr  = reset_counters || (wr_en && a == 0 && wr_data[2]);
    setv = '0;
    if (clr) begin
      for (int j = 0; j < NCNT; j++) m_cnt[j] = 0;
    end else begin
      for (int j = 0; j < NCNT; j++) begin
        if (wr_en && is_cnt && k == j) begin
          if (is_hi) m_cnt[j] = (m_cnt[j] & 64'hFFFF_FFFF) | ((64'(wr_data) << 32) & cmax);
          else       m_cnt[j] = (m_cnt[j] & ~64'hFFFF_FFFF) | 64'(wr_data);
        end else if (on && m_mask[j] && ((j == 0) ? 1'b1 : event_in[j-1])) begin
          if (m_cnt[j] == cmax) begin m_cnt[j] = 0; setv[j] = 1'b1; end
          else m_cnt[j] = m_cnt[j] + 1;
        end
      end
    end
    if (wr_en && is_cnt && m_sh_idx == k) m_sh_valid = 0;
    if (clr) m_sh_valid = 0;
    if (clr) m_ovf = '0;
    else begin
      if (wr_en && a == 2) m_ovf = m_ovf & ~wr_data[NCNT-1:0];
      m_ovf = m_ovf | setv;
    end
    if (wr_en && a == 0) begin m_en = wr_data[0]; m_frz = wr_data[1]; end
    if (wr_en && a == 1) m_mask = wr_data[NCNT-1:0];
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_ni);
      if (!rst_ni) m_reset();
      else m_step();
    end
  end

  // Compare process: outputs are checked on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("rd_valid", 32'(rd_valid_o), 32'(m_rd_valid));
      chk("rd_data", rd_data_o, m_rd_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(int a, logic [31:0] d);
    addr = AW'(a); wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_expect(string nm, int a, logic [31:0] e);
    addr = AW'(a); rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk(nm, rd_data_o, e);
  endtask

  initial begin
    #2 rst_ni = 1'b0;
    idle(3);
    chk("reset_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("reset_rd_data", rd_data_o, 32'd0);
    rst_ni = 1'b1;

    // Free-running cycle counter after reset release
    idle(10);
    rd_expect("cyc_lo_after_10", 4, 32'd10);
    rd_expect("cyc_hi", 5, 32'd0);

    // Masked event counting
    wr(1, 32'h2);
    event_in = '1; idle(7); event_in = '0;
    rd_expect("ev1_count", 6, 32'd7);
    rd_expect("ev2_masked", 8, 32'd0);
    rd_expect("cyc_masked_hold", 4, 32'd13);

    // Wrap and overflow
    wr(6, 32'hFFFF_FFFF); wr(7, 32'h0000_FFFF);
    event_in = 4'b0001; idle(1); event_in = '0;
    rd_expect("wrap_lo", 6, 32'd0);
    rd_expect("ovf_set", 2, 32'h2);
    wr(2, 32'h2);
    rd_expect("ovf_w1c", 2, 32'h0);
    wr(6, 32'hFFFF_FFFF); wr(7, 32'h0000_FFFF);
    event_in = 4'b0001; wr(2, 32'h2); event_in = '0;
    rd_expect("ovf_set_beats_w1c", 2, 32'h2);

    // Atomic wide read through the HI shadow
    wr(1, 32'h1F);
    wr(7, 32'h1234);
    wr(4, 32'hFFFF_FFFE); wr(5, 32'h0);
    rd_expect("shadow_lo", 4, 32'hFFFF_FFFE);
    idle(4);
    rd_expect("shadow_hi", 5, 32'h0);
    rd_expect("live_hi_other", 7, 32'h1234);

    // Freeze: counters hold, writes still apply, resume afterwards
    wr(0, 32'h3);
    wr(5, 32'h0); wr(4, 32'd100);
    event_in = '1; idle(20); event_in = '0;
    wr(8, 32'hABCD);
    rd_expect("frz_cnt0", 4, 32'd100);
    rd_expect("frz_write", 8, 32'hABCD);
    rd_expect("frz_cnt1", 6, 32'd0);
    wr(0, 32'h1);
    idle(3);
    rd_expect("resume_cnt0", 4, 32'd103);

    // Clear via reset_counters and via CTRL.clear_all
    event_in = 4'b0101; idle(3);
    reset_counters = 1'b1; idle(1); reset_counters = 1'b0; event_in = '0;
    rd_expect("rc_cnt0", 4, 32'd0);
    rd_expect("rc_ovf", 2, 32'd0);
    rd_expect("rc_cnt1", 6, 32'd0);
    rd_expect("rc_ctrl", 0, 32'h1);
    rd_expect("rc_mask", 1, 32'h1F);
    wr(1, 32'h15);
    idle(5);
    wr(0, 32'h5);
    rd_expect("clr_cnt0", 4, 32'd0);
    rd_expect("clr_ctrl", 0, 32'h1);
    rd_expect("clr_mask", 1, 32'h15);
    wr(1, 32'h1F);

    // Reset with a read in flight
    event_in = '1; addr = AW'(4); rd_en = 1'b1;
    #2 rst_ni = 1'b0;
    @(negedge clk);
    rd_en = 1'b0;
    chk("inflight_valid", 32'(rd_valid_o), 32'd0);
    chk("inflight_data", rd_data_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1; event_in = '0;
    rd_expect("rel_cnt0_a", 4, 32'd0);
    rd_expect("rel_cnt0_b", 4, 32'd1);
    rd_expect("rel_ctrl", 0, 32'h1);
    rd_expect("rel_mask", 1, 32'h1F);
    rd_expect("rel_ovf", 2, 32'h0);

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      event_in       = NE'($urandom);
      rd_en          = ($urandom_range(0, 2) == 0);
      wr_en          = ($urandom_range(0, 3) == 0);
      reset_counters = ($urandom_range(0, 199) == 0);
      addr           = AW'($urandom_range(0, 17));
      case ($urandom_range(0, 3))
        0: wr_data = $urandom;
        1: wr_data = 32'hFFFF_FFFF;
        2: wr_data = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: wr_data = 32'h0000_FFFF;
      endcase
      if (addr == AW'(0))
        wr_data = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 7)) : 32'h1;
      if (addr == AW'(1))
        wr_data = ($urandom_range(0, 3) == 0) ? $urandom : 32'h1F;
      @(negedge clk);
    end
    event_in = '0; rd_en = 1'b0; wr_en = 1'b0; reset_counters = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
